// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state sequencer that issues ALU ops and loads an 8-bit accumulator.
// Defining ALU_SEQ_ZERO_FLAG_EN adds a registered zero-flag output zf.
module alu_sequencer #(
   parameter logic [7:0] AC_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [3:0] instr_op,
   input  logic [7:0] instr_data,
   output logic       alu_en,
   output logic [3:0] alu_op,
   output logic [7:0] ac,
   input  logic [7:0] alu_result,
`ifdef ALU_SEQ_ZERO_FLAG_EN
   output logic       zf,
`endif
   output logic       done,
   output logic       err,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPT, FIN} state_t;
   state_t state;
   logic accept, is_alu, is_ldac, ac_load;
   logic [7:0] ac_next;
   assign instr_ready = state == IDLE;
   assign busy = state != IDLE;
   assign accept = instr_valid && instr_ready;
   assign is_alu = instr_op <= 4'h9;
   assign is_ldac = instr_op == 4'hA;
   // ac is written only by an accepted LDAC or when leaving CAPT
   assign ac_load = (accept && is_ldac) || state == CAPT;
   assign ac_next = state == CAPT ? alu_result : instr_data;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         ac <= AC_RESET;
         alu_en <= 1'b0;
         alu_op <= 4'h0;
         done <= 1'b0;
         err <= 1'b0;
      end else begin
         alu_en <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         if (ac_load) ac <= ac_next;
         case (state)
            IDLE:
               if (accept) begin
                  if (is_alu) begin
                     state <= ISSUE;
                     alu_op <= instr_op;
                     alu_en <= 1'b1;
                  end else begin
                     state <= FIN;
                     done <= 1'b1;
                     err <= !is_ldac;
                  end
               end
            ISSUE: state <= CAPT;
            CAPT: begin
               state <= FIN;
               done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
`ifdef ALU_SEQ_ZERO_FLAG_EN
   always_ff @(posedge clk or negedge rst)
      if (!rst) zf <= AC_RESET == 8'h00;
      else if (ac_load) zf <= ac_next == 8'h00;
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table vectors, hand sequences and random instructions for alu_sequencer,
// checked against an instruction-level accumulator model (zf checks when ALU_SEQ_ZERO_FLAG_EN is defined).
module tb_alu_sequencer;
   localparam logic [7:0] ACR = 8'h5A;
   logic clk = 0, rst = 1, instr_valid = 0;
   logic instr_ready, alu_en, done, err, busy;
   logic [3:0] instr_op = 0, alu_op;
   logic [7:0] instr_data = 0, ac, alu_result = 0, alu_r = 0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic zf;
`endif
   int checks = 0, errors = 0;
   logic [7:0] m_ac = ACR, m_r = 0;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] d;
      logic [7:0] ac;
      logic [1:0] lat;
      logic       e;
   } vec_t;
   vec_t tbl[12];

   alu_sequencer #(.AC_RESET(ACR)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_data(instr_data), .alu_en(alu_en), .alu_op(alu_op),
      .ac(ac), .alu_result(alu_result),
`ifdef ALU_SEQ_ZERO_FLAG_EN
      .zf(zf),
`endif
      .done(done), .err(err), .busy(busy));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] r);
      case (op)
         4'h0: return a;
         4'h1: return a + 8'd1;
         4'h2: return r + a;
         4'h3: return a - r;
         4'h4: return a & r;
         4'h5: return 8'h00;
         4'h6: return a ^ r;
         4'h7: return a | r;
         4'h8: return ~a;
         default: return {a[6:0], 1'b0};
      endcase
   endfunction

   // registered model ALU; op 0 (MOVAC) also copies ac into its operand register
   always @(posedge clk)
      if (alu_en) begin
         alu_result <= alu_fn(alu_op, ac, alu_r);
         if (alu_op == 4'h0) alu_r <= ac;
      end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model(input logic [3:0] op, input logic [7:0] d);
      logic [7:0] n;
      if (op <= 4'h9) begin
         n = alu_fn(op, m_ac, m_r);
         if (op == 4'h0) m_r = m_ac;
         m_ac = n;
      end else if (op == 4'hA) m_ac = d;
   endtask

   task automatic run(input logic [3:0] op, input logic [7:0] d, output int lat, output logic e,
                      output logic [7:0] a, output logic z, output int pulses, output logic ok);
      int n;
      lat = 0; e = 0; a = 0; z = 0; pulses = 0; ok = 1; n = 0;
      instr_op = op; instr_data = d; instr_valid = 1;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         checks++; errors++;
         $display("FAIL accept: ready never rose");
         instr_valid = 0;
         return;
      end
      @(negedge clk);
      instr_valid = 0; instr_op = 4'($urandom); instr_data = 8'($urandom);
      for (int k = 1; k <= 8; k++) begin
         if (alu_en) begin
            pulses++;
            if (alu_op !== op) ok = 0;
         end
         if (instr_ready || !busy || (err && !done)) ok = 0;
         if (done) begin
            lat = k; e = err; a = ac;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            z = zf;
`endif
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic exec(input logic [3:0] op, input logic [7:0] d);
      int lat, pulses; logic e, ok, z; logic [7:0] a;
      run(op, d, lat, e, a, z, pulses, ok);
      model(op, d);
      chk($sformatf("latency op%0h", op), lat, op <= 4'h9 ? 3 : 1);
      chk($sformatf("err op%0h", op), e, op > 4'hA);
      chk($sformatf("ac op%0h", op), a, m_ac);
      chk($sformatf("alu_en pulses op%0h", op), pulses, op <= 4'h9);
      chk($sformatf("issue/handshake op%0h", op), ok, 1);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk($sformatf("zf op%0h", op), z, m_ac == 8'h00);
`endif
   endtask

   initial begin
      int lat, pulses, acc, dones, bad; logic e, ok, z, prev; logic [7:0] a;
      tbl[0]  = '{4'hA, 8'h3C, 8'h3C, 2'd1, 1'b0};
      tbl[1]  = '{4'h0, 8'h00, 8'h3C, 2'd3, 1'b0};
      tbl[2]  = '{4'hA, 8'h05, 8'h05, 2'd1, 1'b0};
      tbl[3]  = '{4'h2, 8'h00, 8'h41, 2'd3, 1'b0};
      tbl[4]  = '{4'hC, 8'h77, 8'h41, 2'd1, 1'b1};
      tbl[5]  = '{4'h1, 8'h00, 8'h42, 2'd3, 1'b0};
      tbl[6]  = '{4'h3, 8'h00, 8'h06, 2'd3, 1'b0};
      tbl[7]  = '{4'h5, 8'h00, 8'h00, 2'd3, 1'b0};
      tbl[8]  = '{4'hF, 8'h00, 8'h00, 2'd1, 1'b1};
      tbl[9]  = '{4'hA, 8'hF0, 8'hF0, 2'd1, 1'b0};
      tbl[10] = '{4'h9, 8'h00, 8'hE0, 2'd3, 1'b0};
      tbl[11] = '{4'hB, 8'h12, 8'hE0, 2'd1, 1'b1};
      #2 rst = 0;
      repeat (2) @(negedge clk);
      chk("reset ac", ac, ACR);
      chk("reset alu_en", alu_en, 0);
      chk("reset alu_op", alu_op, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset busy", busy, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk("reset zf", zf, ACR == 8'h00);
`endif
      rst = 1;
      @(negedge clk);
      chk("ready after reset", instr_ready, 1);

      foreach (tbl[i]) begin
         run(tbl[i].op, tbl[i].d, lat, e, a, z, pulses, ok);
         model(tbl[i].op, tbl[i].d);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d err", i), e, tbl[i].e);
         chk($sformatf("vec%0d ac", i), a, tbl[i].ac);
         chk($sformatf("vec%0d alu_en pulses", i), pulses, tbl[i].lat == 2'd3);
         chk($sformatf("vec%0d issue/handshake", i), ok, 1);
      end

      // instr_valid held high: three INCs, each accepted exactly once
      acc = 0; pulses = 0; dones = 0; bad = 0; prev = 0;
      instr_op = 4'h1; instr_data = 8'h00; instr_valid = 1;
      for (int k = 0; k < 16; k++) begin
         if (alu_en) pulses++;
         if (alu_en && prev) bad++;
         if (instr_ready && busy) bad++;
         if (done) dones++;
         prev = alu_en;
         if (instr_valid && instr_ready) acc++;
         @(negedge clk);
         if (acc == 3) instr_valid = 0;
      end
      repeat (3) model(4'h1, 8'h00);
      chk("held valid accepts", acc, 3);
      chk("held valid alu_en pulses", pulses, 3);
      chk("held valid dones", dones, 3);
      chk("held valid overlap", bad, 0);
      chk("held valid ac", ac, m_ac);

      // reset pulse during CAPT of an ADD aborts it
      instr_op = 4'h2; instr_valid = 1;
      @(negedge clk);
      instr_valid = 0;
      @(negedge clk);
      chk("capt alu_en", alu_en, 0);
      rst = 0;
      #1;
      chk("abort busy", busy, 0);
      chk("abort ac", ac, ACR);
      chk("abort alu_en", alu_en, 0);
      chk("abort alu_op", alu_op, 0);
      @(negedge clk);
      rst = 1;
      m_ac = ACR;
      dones = 0;
      @(negedge clk);
      chk("ready after abort", instr_ready, 1);
      for (int k = 0; k < 5; k++) begin
         if (done) dones++;
         @(negedge clk);
      end
      chk("abort no done", dones, 0);
      chk("abort ac held", ac, ACR);
      exec(4'hA, 8'h99);
      exec(4'h1, 8'h00);

`ifdef ALU_SEQ_ZERO_FLAG_EN
      run(4'hA, 8'h01, lat, e, a, z, pulses, ok);
      model(4'hA, 8'h01);
      chk("zf after LDAC 01", z, 0);
      run(4'h5, 8'h00, lat, e, a, z, pulses, ok);
      model(4'h5, 8'h00);
      chk("zf at CLAC done", z, 1);
`endif

      for (int i = 0; i < 80; i++) exec(4'($urandom_range(0, 15)), 8'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
